// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state encoding and constants for the pipeline hazard controller
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    LU_STALL = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         BUB_CNT_W = 3;

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating event counter used for hazard performance statistics
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use bubbles, branch flush and memory freeze sequencing for the 5-stage core
// HAZARD_PERF_CNT_EN adds saturating stall/flush/freeze cycle counters.
module hazard_ctrl_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [4:0] Rs1_i,
  input  logic [4:0] Rs2_i,
  input  logic       UseRs1_i,
  input  logic       UseRs2_i,
  input  logic       MemRead_EX_i,
  input  logic [4:0] Rd_EX_i,
  input  logic       BranchTaken_i,
  input  logic       MemStall_i,
  output logic       PCWrite_o,
  output logic       IFIDWrite_o,
  output logic       IFIDFlush_o,
  output logic       IDEXBubble_o,
  output logic       PipeFreeze_o
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] LuStallCnt_o
  , output logic [CNT_W-1:0] FlushCnt_o
  , output logic [CNT_W-1:0] FreezeCnt_o
`endif
);

  localparam logic [BUB_CNT_W-1:0] LU_RELOAD = BUB_CNT_W'(LOAD_USE_BUBBLES - 1);
  localparam logic [BUB_CNT_W-1:0] BUB_ONE   = BUB_CNT_W'(1);

  hz_state_e             state_q, state_d;
  hz_state_e             ret_q, ret_d;
  hz_state_e             eval_st;
  logic [BUB_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  lu;

  assign lu = MemRead_EX_i && (Rd_EX_i != REG_ZERO) &&
              ((UseRs1_i && (Rs1_i == Rd_EX_i)) || (UseRs2_i && (Rs2_i == Rd_EX_i)));

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    cnt_d        = cnt_q;
    PCWrite_o    = 1'b1;
    IFIDWrite_o  = 1'b1;
    IFIDFlush_o  = 1'b0;
    IDEXBubble_o = 1'b0;
    PipeFreeze_o = 1'b0;

    // Once memory releases, MEM_WAIT behaves exactly like the state it interrupted.
    eval_st = state_q;
    if ((state_q == MEM_WAIT) && !MemStall_i) begin
      eval_st = ret_q;
    end

    case (eval_st)
      IDLE: begin
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
        IDEXBubble_o = 1'b1;
        if (start_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (MemStall_i) begin
          PCWrite_o    = 1'b0;
          IFIDWrite_o  = 1'b0;
          PipeFreeze_o = 1'b1;
          ret_d        = RUN;
          state_d      = MEM_WAIT;
        end else begin
          state_d = RUN;
          if (lu) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              cnt_d   = LU_RELOAD;
              state_d = LU_STALL;
            end
          end else if (BranchTaken_i) begin
            IFIDFlush_o = 1'b1;
          end
        end
      end
      LU_STALL: begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        if (MemStall_i) begin
          PipeFreeze_o = 1'b1;
          ret_d        = LU_STALL;
          state_d      = MEM_WAIT;
        end else begin
          IDEXBubble_o = 1'b1;
          cnt_d        = cnt_q - BUB_ONE;
          state_d      = (cnt_q == BUB_ONE) ? RUN : LU_STALL;
        end
      end
      default: begin
        PCWrite_o    = 1'b0;
        IFIDWrite_o  = 1'b0;
        PipeFreeze_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.W(CNT_W)) u_lu_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (IDEXBubble_o && (state_q != IDLE)),
    .cnt_o (LuStallCnt_o)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (IFIDFlush_o),
    .cnt_o (FlushCnt_o)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_freeze_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (PipeFreeze_o),
    .cnt_o (FreezeCnt_o)
  );
`endif

endmodule
